exec_sequencer: RTL and testbench

Multi-cycle execution sequencer for the pico-MIPS core. It runs a shift-add multiplier for MULT and the switch-input and LED-output handshakes for STIN and LOUT. While one of these operations is in flight it stalls the program counter and instruction fetch. It sits beside the instruction decoder, takes the decoder's `mult_req`, `read_in` and `write_out` strobes, and drives the register-file write port for MULT and STIN results.

---
 rtl/exec_sequencer.sv | 148 ++++++++++++++
 tb/tb_exec_sequencer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_sequencer.sv
// Multi-cycle execution sequencer: shift-add MULT, STIN/LOUT handshakes,
// pipeline stall generation and register write-back for the pico-MIPS core.
module exec_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic             mult_req,
    input  logic             read_in,
    input  logic             write_out,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [WIDTH-1:0] sw_data,
    input  logic             sw_valid,
    output logic             sw_ack,
    input  logic             out_ready,
    output logic [WIDTH-1:0] lout_data,
    output logic             lout_valid,
    output logic             stall,
    output logic             wb_en,
    output logic [WIDTH-1:0] wb_data
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        MUL,
        IN_WAIT,
        OUT_WAIT,
        DONE
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             is_wb;

    // Modular accumulate: the low WIDTH bits are correct for signed and unsigned operands.
    function automatic logic [WIDTH-1:0] wrap_add(input logic [WIDTH-1:0] x,
                                                  input logic [WIDTH-1:0] y);
        return x + y;
    endfunction

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        sw_ack    = 1'b0;
        case (state)
            IDLE: begin
                stall = mult_req | read_in | write_out;
                if (mult_req) begin
                    state_nxt = MUL;
                end else if (read_in) begin
                    state_nxt = IN_WAIT;
                end else if (write_out) begin
                    state_nxt = OUT_WAIT;
                end
            end
            MUL: begin
                stall = 1'b1;
                if (cnt == CNT_LAST) begin
                    state_nxt = DONE;
                end
            end
            IN_WAIT: begin
                stall = 1'b1;
                if (sw_valid) begin
                    sw_ack    = 1'b1;
                    state_nxt = DONE;
                end
            end
            OUT_WAIT: begin
                stall = 1'b1;
                if (lout_valid && out_ready) begin
                    state_nxt = DONE;
                end
            end
            // Strobes seen here still belong to the finished instruction.
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            a_reg      <= '0;
            b_reg      <= '0;
            acc        <= '0;
            cnt        <= '0;
            is_wb      <= 1'b0;
            lout_data  <= '0;
            lout_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mult_req) begin
                        a_reg <= op_a;
                        b_reg <= op_b;
                        acc   <= '0;
                        cnt   <= '0;
                        is_wb <= 1'b1;
                    end else if (read_in) begin
                        is_wb <= 1'b1;
                    end else if (write_out) begin
                        lout_data  <= op_a;
                        lout_valid <= 1'b1;
                        is_wb      <= 1'b0;
                    end
                end
                MUL: begin
                    if (b_reg[0]) begin
                        acc <= wrap_add(acc, a_reg);
                    end
                    a_reg <= a_reg << 1;
                    b_reg <= b_reg >> 1;
                    cnt   <= cnt + CNT_W'(1);
                end
                IN_WAIT: begin
                    if (sw_valid) begin
                        acc <= sw_data;
                    end
                end
                OUT_WAIT: begin
                    if (lout_valid && out_ready) begin
                        lout_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign wb_en   = (state == DONE) && is_wb;
    assign wb_data = acc;

endmodule

// File: tb/tb_exec_sequencer.sv
// Bench for exec_sequencer: directed and randomized MULT/STIN/LOUT operations
// checked cycle by cycle against timing and results derived from the operation rules.
module tb_exec_sequencer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         n_reset;
    logic         mult_req, read_in, write_out;
    logic [W-1:0] op_a, op_b, sw_data;
    logic         sw_valid, sw_ack, out_ready;
    logic [W-1:0] lout_data;
    logic         lout_valid, stall, wb_en;
    logic [W-1:0] wb_data;

    int checks = 0;
    int errors = 0;

    exec_sequencer #(.WIDTH(W)) dut (
        .clk        (clk),
        .n_reset    (n_reset),
        .mult_req   (mult_req),
        .read_in    (read_in),
        .write_out  (write_out),
        .op_a       (op_a),
        .op_b       (op_b),
        .sw_data    (sw_data),
        .sw_valid   (sw_valid),
        .sw_ack     (sw_ack),
        .out_ready  (out_ready),
        .lout_data  (lout_data),
        .lout_valid (lout_valid),
        .stall      (stall),
        .wb_en      (wb_en),
        .wb_data    (wb_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        mult_req  = 1'b0;
        read_in   = 1'b0;
        write_out = 1'b0;
        sw_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic idle_check(input string tag);
        @(negedge clk);
        check({tag, "_idle_stall"}, 32'(stall), 32'(0));
        check({tag, "_idle_wb_en"}, 32'(wb_en), 32'(0));
        check({tag, "_idle_sw_ack"}, 32'(sw_ack), 32'(0));
        next_cycle();
    endtask

    // Product truncated to W bits; stall for cycles 0..W, write-back in cycle W+1.
    task automatic run_mult(input logic [W-1:0] a, input logic [W-1:0] b, input logic with_read);
        int           p;
        logic [W-1:0] exp;
        p   = int'(a) * int'(b);
        exp = p[W-1:0];
        mult_req  = 1'b1;
        read_in   = with_read;
        write_out = 1'($urandom);
        op_a      = a;
        op_b      = b;
        sw_valid  = with_read;
        sw_data   = 8'($urandom);
        out_ready = 1'($urandom);
        for (int k = 0; k <= W + 1; k++) begin
            if (k == 1) begin
                op_a = 8'($urandom);
                op_b = 8'($urandom);
            end
            @(negedge clk);
            check("mult_stall", 32'(stall), 32'(k <= W));
            check("mult_wb_en", 32'(wb_en), 32'(k == W + 1));
            check("mult_sw_ack", 32'(sw_ack), 32'(0));
            check("mult_lout_valid", 32'(lout_valid), 32'(0));
            if (k == W + 1) check("mult_wb_data", 32'(wb_data), 32'(exp));
            next_cycle();
        end
        clear_inputs();
        idle_check("mult");
    endtask

    // d = number of IN_WAIT cycles with sw_valid low before the data arrives.
    task automatic run_stin(input logic [W-1:0] data, input int d, input logic also_out);
        mult_req  = 1'b0;
        read_in   = 1'b1;
        write_out = also_out;
        op_a      = 8'($urandom);
        sw_valid  = (d == 0) ? 1'b1 : 1'($urandom);
        sw_data   = 8'($urandom);
        out_ready = 1'($urandom);
        for (int k = 0; k <= d + 2; k++) begin
            if (k >= 1) begin
                sw_valid = (k == d + 1);
                sw_data  = (k == d + 1) ? data : 8'($urandom);
            end
            @(negedge clk);
            check("stin_stall", 32'(stall), 32'(k <= d + 1));
            check("stin_sw_ack", 32'(sw_ack), 32'(k == d + 1));
            check("stin_wb_en", 32'(wb_en), 32'(k == d + 2));
            check("stin_lout_valid", 32'(lout_valid), 32'(0));
            if (k == d + 2) check("stin_wb_data", 32'(wb_data), 32'(data));
            next_cycle();
        end
        clear_inputs();
        idle_check("stin");
    endtask

    // d = number of OUT_WAIT cycles with out_ready low before the transfer.
    task automatic run_lout(input logic [W-1:0] data, input int d);
        mult_req  = 1'b0;
        read_in   = 1'b0;
        write_out = 1'b1;
        op_a      = data;
        out_ready = 1'($urandom);
        sw_valid  = 1'($urandom);
        for (int k = 0; k <= d + 2; k++) begin
            if (k >= 1) begin
                op_a      = 8'($urandom);
                out_ready = (k == d + 1);
                sw_valid  = 1'($urandom);
            end
            @(negedge clk);
            check("lout_stall", 32'(stall), 32'(k <= d + 1));
            check("lout_valid", 32'(lout_valid), 32'((k >= 1) && (k <= d + 1)));
            check("lout_wb_en", 32'(wb_en), 32'(0));
            check("lout_sw_ack", 32'(sw_ack), 32'(0));
            if (k >= 1) check("lout_data", 32'(lout_data), 32'(data));
            next_cycle();
        end
        clear_inputs();
        @(negedge clk);
        check("lout_data_after", 32'(lout_data), 32'(data));
        next_cycle();
        idle_check("lout");
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        n_reset = 1'b0;
        clear_inputs();
        op_a    = '0;
        op_b    = '0;
        sw_data = '0;
        #2;
        check("rst_stall", 32'(stall), 32'(0));
        check("rst_wb_en", 32'(wb_en), 32'(0));
        check("rst_wb_data", 32'(wb_data), 32'(0));
        check("rst_lout_data", 32'(lout_data), 32'(0));
        check("rst_lout_valid", 32'(lout_valid), 32'(0));
        check("rst_sw_ack", 32'(sw_ack), 32'(0));
        mult_req = 1'b1;
        #1;
        check("rst_stall_req", 32'(stall), 32'(1));
        mult_req = 1'b0;
        #20;
        n_reset = 1'b1;
        next_cycle();
        idle_check("post_rst");

        run_mult(8'd7, 8'd9, 1'b0);
        run_mult(8'hFF, 8'h02, 1'b0);
        run_mult(8'h10, 8'h10, 1'b0);
        run_mult(8'hFF, 8'hFF, 1'b0);
        run_mult(8'h00, 8'h55, 1'b0);
        run_stin(8'hA5, 4, 1'b0);
        run_stin(8'h5A, 0, 1'b1);
        run_lout(8'h3C, 3);
        run_lout(8'hC3, 0);
        run_mult(8'h0B, 8'h0D, 1'b1);

        // Async reset in MUL cycle 4 with the request dropped.
        mult_req = 1'b1;
        op_a     = 8'h21;
        op_b     = 8'h33;
        for (int k = 0; k < 4; k++) next_cycle();
        #2;
        n_reset  = 1'b0;
        mult_req = 1'b0;
        #1;
        check("mulrst_stall", 32'(stall), 32'(0));
        check("mulrst_wb_en", 32'(wb_en), 32'(0));
        check("mulrst_wb_data", 32'(wb_data), 32'(0));
        #1;
        n_reset = 1'b1;
        next_cycle();
        idle_check("mulrst");
        run_mult(8'd3, 8'd5, 1'b0);

        // Async reset while waiting for switch data, request still present.
        read_in = 1'b1;
        for (int k = 0; k < 3; k++) next_cycle();
        #2;
        sw_valid = 1'b1;
        n_reset  = 1'b0;
        #1;
        check("inrst_sw_ack", 32'(sw_ack), 32'(0));
        check("inrst_stall_req", 32'(stall), 32'(1));
        check("inrst_wb_en", 32'(wb_en), 32'(0));
        clear_inputs();
        #1;
        n_reset = 1'b1;
        next_cycle();
        idle_check("inrst");

        // Async reset while an LED transfer is pending.
        write_out = 1'b1;
        op_a      = 8'h77;
        next_cycle();
        write_out = 1'b0;
        next_cycle();
        check("outrst_valid_pre", 32'(lout_valid), 32'(1));
        #2;
        n_reset = 1'b0;
        #1;
        check("outrst_valid", 32'(lout_valid), 32'(0));
        check("outrst_data", 32'(lout_data), 32'(0));
        check("outrst_stall", 32'(stall), 32'(0));
        #1;
        n_reset = 1'b1;
        next_cycle();
        idle_check("outrst");

        for (int i = 0; i < 30; i++) begin
            case ($urandom_range(0, 2))
                0:       run_mult(8'($urandom), 8'($urandom), 1'($urandom));
                1:       run_stin(8'($urandom), int'($urandom_range(0, 6)), 1'($urandom));
                default: run_lout(8'($urandom), int'($urandom_range(0, 5)));
            endcase
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
